// File: rtl/pid_filter_pkg.sv
// Shared endpoint map and config-op decode for the multichannel PID stage.
package pid_filter_pkg;

    localparam logic [15:0] pid_setpoint_addr = 16'h0200;
    localparam logic [15:0] pid_p_coef_addr   = 16'h0201;
    localparam logic [15:0] pid_i_coef_addr   = 16'h0202;
    localparam logic [15:0] pid_d_coef_addr   = 16'h0203;
    localparam logic [15:0] pid_lock_en_addr  = 16'h0204;
    localparam logic [15:0] pid_clr_rqst_addr = 16'h0205;
    localparam logic [15:0] pid_inv_addr      = 16'h0206;

    typedef enum logic [2:0] {
        CFG_NONE, CFG_SETPT, CFG_P, CFG_I, CFG_D, CFG_LOCK, CFG_CLR, CFG_INV
    } cfg_op_e;

    function automatic cfg_op_e cfg_decode(input logic [15:0] addr);
        case (addr)
            pid_setpoint_addr: return CFG_SETPT;
            pid_p_coef_addr:   return CFG_P;
            pid_i_coef_addr:   return CFG_I;
            pid_d_coef_addr:   return CFG_D;
            pid_lock_en_addr:  return CFG_LOCK;
            pid_clr_rqst_addr: return CFG_CLR;
            pid_inv_addr:      return CFG_INV;
            default:           return CFG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pid_sat_add.sv
// Combinational signed add of a wide delta onto an accumulator, clamped to W_OUT.
module pid_sat_add #(
    parameter int W_IN  = 39,
    parameter int W_OUT = 32
) (
    input  logic signed [W_OUT-1:0] acc_in,
    input  logic signed [W_IN-1:0]  delta_in,
    output logic signed [W_OUT-1:0] sum_out
);
    localparam int W_SUM = W_IN + 1;

    logic signed [W_SUM-1:0] sum, max_v, min_v;

    always_comb begin
        sum   = {{(W_SUM-W_OUT){acc_in[W_OUT-1]}}, acc_in} + {delta_in[W_IN-1], delta_in};
        max_v = {{(W_SUM-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
        min_v = {{(W_SUM-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};
        if (sum > max_v)
            sum_out = max_v[W_OUT-1:0];
        else if (sum < min_v)
            sum_out = min_v[W_OUT-1:0];
        else
            sum_out = sum[W_OUT-1:0];
    end

endmodule

// File: rtl/pid_filter.sv
// Time-multiplexed velocity-form PID, 4-cycle pipeline, per-channel state in flops.
// Optional PID_INV_EN adds a per-channel error-polarity inversion register.
module pid_filter
    import pid_filter_pkg::*;
#(
    parameter int W_CHAN    = 5,
    parameter int N_CHAN    = 8,
    parameter int W_DATA    = 18,
    parameter int W_COEF    = 16,
    parameter int W_OUT     = 32,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     dv_in,
    input  logic [W_CHAN-1:0]        chan_in,
    input  logic signed [W_DATA-1:0] data_in,
    input  logic                     wr_en,
    input  logic [W_WR_ADDR-1:0]     wr_addr,
    input  logic [W_WR_CHAN-1:0]     wr_chan,
    input  logic [W_WR_DATA-1:0]     wr_data,
    output logic                     dv_out,
    output logic [W_CHAN-1:0]        chan_out,
    output logic signed [W_OUT-1:0]  data_out,
    output logic [N_CHAN-1:0]        overrun_out
);
    localparam int W_IDX   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int N_SLOT  = 1 << W_IDX;
    localparam int W_ERR   = W_DATA + 1;
    localparam int W_K     = W_COEF + 2;
    localparam int W_PROD  = W_K + W_ERR;
    localparam int W_DELTA = W_PROD + 2;

    typedef struct packed {
        logic [W_IDX-1:0]        chan;
        logic signed [W_ERR-1:0] e, e1, e2;
        logic signed [W_COEF-1:0] kp, ki, kd;
        logic signed [W_OUT-1:0] acc;
    } s1_t;

    typedef struct packed {
        logic [W_IDX-1:0]         chan;
        logic signed [W_PROD-1:0] pr0, pr1, pr2;
        logic signed [W_ERR-1:0]  e, e1;
        logic signed [W_OUT-1:0]  acc;
    } s2_t;

    typedef struct packed {
        logic [W_IDX-1:0]          chan;
        logic signed [W_DELTA-1:0] delta;
        logic signed [W_ERR-1:0]   e, e1;
        logic signed [W_OUT-1:0]   acc;
    } s3_t;

    logic signed [W_DATA-1:0] sp_q [N_SLOT], sp_d [N_SLOT];
    logic signed [W_COEF-1:0] kp_q [N_SLOT], kp_d [N_SLOT];
    logic signed [W_COEF-1:0] ki_q [N_SLOT], ki_d [N_SLOT];
    logic signed [W_COEF-1:0] kd_q [N_SLOT], kd_d [N_SLOT];
    logic signed [W_ERR-1:0]  e1_q [N_SLOT], e1_d [N_SLOT];
    logic signed [W_ERR-1:0]  e2_q [N_SLOT], e2_d [N_SLOT];
    logic signed [W_OUT-1:0]  acc_q [N_SLOT], acc_d [N_SLOT];
    logic [N_SLOT-1:0]        lock_q, lock_d, ovr_q, ovr_d;
`ifdef PID_INV_EN
    logic [N_SLOT-1:0]        inv_q, inv_d;
`endif

    logic [3:1] vld_pipe_q, vld_pipe_d;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;
    s3_t        s3_q, s3_d;
    logic                    dv_out_q, dv_out_d;
    logic [W_CHAN-1:0]       chan_out_q, chan_out_d;
    logic signed [W_OUT-1:0] data_out_q, data_out_d;

    cfg_op_e                 op;
    logic                    wr_hit, clr, in_ok, busy, accept, wb;
    logic [W_IDX-1:0]        wr_idx, in_idx;
    logic signed [W_ERR-1:0] e_new;
    logic signed [W_K-1:0]   k0, k1, k2;
    logic signed [W_OUT-1:0] acc_new;
    logic                    unused_wr;

    assign unused_wr = ^wr_data[W_WR_DATA-1:W_DATA];

    pid_sat_add #(.W_IN(W_DELTA), .W_OUT(W_OUT)) u_sat (
        .acc_in   (s3_q.acc),
        .delta_in (s3_q.delta),
        .sum_out  (acc_new)
    );

    always_comb begin
        op     = cfg_decode(16'(wr_addr));
        wr_hit = wr_en && (32'(wr_chan) < N_CHAN);
        wr_idx = wr_chan[W_IDX-1:0];
        clr    = wr_hit && (op == CFG_CLR);
        in_idx = chan_in[W_IDX-1:0];
        in_ok  = dv_in && (32'(chan_in) < N_CHAN) && lock_q[in_idx];
        // Anything of this channel still in P1-P3 would read stale e1/e2/acc.
        busy   = (vld_pipe_q[1] && s1_q.chan == in_idx) ||
                 (vld_pipe_q[2] && s2_q.chan == in_idx) ||
                 (vld_pipe_q[3] && s3_q.chan == in_idx);
        accept = in_ok && !busy && !(clr && wr_idx == in_idx);

`ifdef PID_INV_EN
        e_new = inv_q[in_idx] ? W_ERR'(data_in) - W_ERR'(sp_q[in_idx])
                              : W_ERR'(sp_q[in_idx]) - W_ERR'(data_in);
`else
        e_new = W_ERR'(sp_q[in_idx]) - W_ERR'(data_in);
`endif

        s1_d = '{chan: in_idx, e: e_new, e1: e1_q[in_idx], e2: e2_q[in_idx],
                 kp: kp_q[in_idx], ki: ki_q[in_idx], kd: kd_q[in_idx], acc: acc_q[in_idx]};

        k0 = W_K'($signed(s1_q.kp)) + W_K'($signed(s1_q.ki)) + W_K'($signed(s1_q.kd));
        k1 = W_K'($signed(s1_q.kp)) + (W_K'($signed(s1_q.kd)) <<< 1);
        k2 = W_K'($signed(s1_q.kd));
        s2_d.chan = s1_q.chan;
        s2_d.pr0  = W_PROD'(k0) * W_PROD'($signed(s1_q.e));
        s2_d.pr1  = W_PROD'(k1) * W_PROD'($signed(s1_q.e1));
        s2_d.pr2  = W_PROD'(k2) * W_PROD'($signed(s1_q.e2));
        s2_d.e    = s1_q.e;
        s2_d.e1   = s1_q.e1;
        s2_d.acc  = s1_q.acc;

        s3_d.chan  = s2_q.chan;
        s3_d.delta = W_DELTA'($signed(s2_q.pr0)) - W_DELTA'($signed(s2_q.pr1))
                   + W_DELTA'($signed(s2_q.pr2));
        s3_d.e     = s2_q.e;
        s3_d.e1    = s2_q.e1;
        s3_d.acc   = s2_q.acc;

        // A clear on a channel kills its ops in every stage, including writeback.
        vld_pipe_d[1] = accept;
        vld_pipe_d[2] = vld_pipe_q[1] && !(clr && wr_idx == s1_q.chan);
        vld_pipe_d[3] = vld_pipe_q[2] && !(clr && wr_idx == s2_q.chan);
        wb            = vld_pipe_q[3] && !(clr && wr_idx == s3_q.chan);

        dv_out_d   = wb;
        chan_out_d = wb ? W_CHAN'(s3_q.chan) : chan_out_q;
        data_out_d = wb ? acc_new : data_out_q;

        sp_d   = sp_q;
        kp_d   = kp_q;
        ki_d   = ki_q;
        kd_d   = kd_q;
        e1_d   = e1_q;
        e2_d   = e2_q;
        acc_d  = acc_q;
        lock_d = lock_q;
        ovr_d  = ovr_q;
`ifdef PID_INV_EN
        inv_d  = inv_q;
`endif

        if (wr_hit) begin
            case (op)
                CFG_SETPT: sp_d[wr_idx]   = wr_data[W_DATA-1:0];
                CFG_P:     kp_d[wr_idx]   = wr_data[W_COEF-1:0];
                CFG_I:     ki_d[wr_idx]   = wr_data[W_COEF-1:0];
                CFG_D:     kd_d[wr_idx]   = wr_data[W_COEF-1:0];
                CFG_LOCK:  lock_d[wr_idx] = wr_data[0];
`ifdef PID_INV_EN
                CFG_INV:   inv_d[wr_idx]  = wr_data[0];
`endif
                default: ;
            endcase
        end

        if (wb) begin
            acc_d[s3_q.chan] = acc_new;
            e1_d[s3_q.chan]  = s3_q.e;
            e2_d[s3_q.chan]  = s3_q.e1;
        end

        if (in_ok && busy)
            ovr_d[in_idx] = 1'b1;

        if (clr) begin
            e1_d[wr_idx]  = '0;
            e2_d[wr_idx]  = '0;
            acc_d[wr_idx] = '0;
            ovr_d[wr_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < N_SLOT; c++) begin
                sp_q[c]  <= '0;
                kp_q[c]  <= '0;
                ki_q[c]  <= '0;
                kd_q[c]  <= '0;
                e1_q[c]  <= '0;
                e2_q[c]  <= '0;
                acc_q[c] <= '0;
            end
            lock_q     <= '0;
            ovr_q      <= '0;
`ifdef PID_INV_EN
            inv_q      <= '0;
`endif
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            dv_out_q   <= 1'b0;
            chan_out_q <= '0;
            data_out_q <= '0;
        end else begin
            sp_q       <= sp_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            e1_q       <= e1_d;
            e2_q       <= e2_d;
            acc_q      <= acc_d;
            lock_q     <= lock_d;
            ovr_q      <= ovr_d;
`ifdef PID_INV_EN
            inv_q      <= inv_d;
`endif
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            dv_out_q   <= dv_out_d;
            chan_out_q <= chan_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign dv_out      = dv_out_q;
    assign chan_out    = chan_out_q;
    assign data_out    = data_out_q;
    assign overrun_out = ovr_q[N_CHAN-1:0];

endmodule

// File: tb/tb_pid_filter.sv
// Directed bench for pid_filter with hand-computed control words.
module tb_pid_filter;
    import pid_filter_pkg::*;

    logic               clk_in = 1'b0;
    logic               rst_n_in;
    logic               dv_in;
    logic [4:0]         chan_in;
    logic signed [17:0] data_in;
    logic               wr_en;
    logic [15:0]        wr_addr;
    logic [15:0]        wr_chan;
    logic [47:0]        wr_data;
    logic               dv_out;
    logic [4:0]         chan_out;
    logic signed [31:0] data_out;
    logic [7:0]         overrun_out;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;
    logic signed [31:0] last;

    always #5 clk_in = ~clk_in;

    pid_filter dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .dv_in       (dv_in),
        .chan_in     (chan_in),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_chan     (wr_chan),
        .wr_data     (wr_data),
        .dv_out      (dv_out),
        .chan_out    (chan_out),
        .data_out    (data_out),
        .overrun_out (overrun_out)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input int ch, input longint d);
        wr_en = 1'b1; wr_addr = a; wr_chan = 16'(ch); wr_data = 48'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drv(input int ch, input int v);
        dv_in = 1'b1; chan_in = 5'(ch); data_in = 18'(v);
        tick();
        dv_in = 1'b0;
    endtask

    // Sample, then check dv_out stays low for 3 edges and rises on the 4th.
    task automatic run(input string tag, input int ch, input int v, input logic signed [63:0] exp);
        drv(ch, v);
        tick();
        tick();
        chk({tag, ".early"}, dv_out, 0);
        tick();
        chk({tag, ".dv"}, dv_out, 1);
        chk({tag, ".chan"}, chan_out, ch);
        chk({tag, ".data"}, data_out, exp);
    endtask

    task automatic win(input int n, output int c, output logic signed [31:0] l);
        c = 0;
        l = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (dv_out) begin
                c++;
                l = data_out;
            end
        end
    endtask

    task automatic setup(input int ch, input int sp, input int p, input int i, input int d);
        wr(pid_setpoint_addr, ch, sp);
        wr(pid_p_coef_addr, ch, p);
        wr(pid_i_coef_addr, ch, i);
        wr(pid_d_coef_addr, ch, d);
        wr(pid_lock_en_addr, ch, 1);
    endtask

    initial begin
        rst_n_in = 1'b0; dv_in = 1'b0; chan_in = '0; data_in = '0;
        wr_en = 1'b0; wr_addr = '0; wr_chan = '0; wr_data = '0;
        #3;
        chk("rst.dv", dv_out, 0);
        chk("rst.chan", chan_out, 0);
        chk("rst.data", data_out, 0);
        chk("rst.ovr", overrun_out, 0);
        repeat (2) @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        tick();

        setup(2, 100, 1, 0, 0);
        run("p0", 2, 90, 10);
        run("p1", 2, 80, 20);

        setup(0, 0, 0, 2, 0);
        run("i0", 0, -5, 10);
        run("i1", 0, -5, 20);
        run("i2", 0, -5, 30);

        setup(1, 0, 0, 0, 1);
        run("d0", 1, 0, 0);
        run("d1", 1, -7, 7);
        run("d2", 1, -7, 0);

        setup(5, 131071, 0, 32767, 0);
        run("satp0", 5, -131072, 2147483647);
        run("satp1", 5, -131072, 2147483647);
        setup(6, -131072, 0, 32767, 0);
        run("satn0", 6, 131071, -64'sd2147483648);

        // Same-channel hazard, then clear, then clear racing an in-flight op.
        setup(3, 0, 0, 1, 0);
        drv(3, -1);
        tick();
        drv(3, -1);
        win(6, cnt, last);
        chk("haz.cnt", cnt, 1);
        chk("haz.data", last, 1);
        chk("haz.ovr", overrun_out, 8'h08);
        wr(pid_clr_rqst_addr, 3, 0);
        chk("clr.ovr", overrun_out, 0);
        drv(3, -1);
        win(6, cnt, last);
        chk("clr.cnt", cnt, 1);
        chk("clr.acc", last, 1);
        drv(3, -1);
        wr(pid_clr_rqst_addr, 3, 0);
        win(6, cnt, last);
        chk("flush.cnt", cnt, 0);
        drv(3, -1);
        win(6, cnt, last);
        chk("flush.acc", last, 1);

        // Lock off: samples dropped without touching state.
        wr(pid_setpoint_addr, 4, 0);
        wr(pid_i_coef_addr, 4, 1);
        drv(4, -3);
        tick(); tick(); tick();
        drv(4, -3);
        win(6, cnt, last);
        chk("lock.cnt", cnt, 0);
        wr(pid_lock_en_addr, 4, 1);
        drv(4, -3);
        win(6, cnt, last);
        chk("lock.acc", last, 3);

        // Coefficient write in the same cycle as a sample uses the old value.
        setup(7, 0, 1, 0, 0);
        wr_en = 1'b1; wr_addr = pid_p_coef_addr; wr_chan = 16'd7; wr_data = 48'd5;
        dv_in = 1'b1; chan_in = 5'd7; data_in = -18'sd1;
        tick();
        wr_en = 1'b0; dv_in = 1'b0;
        win(6, cnt, last);
        chk("cfg.old", last, 1);
        drv(7, -2);
        win(6, cnt, last);
        chk("cfg.new", last, 6);

        // Out-of-range channel on both the write bus and the sample path.
        wr(pid_lock_en_addr, 8, 0);
        drv(8, -5);
        win(6, cnt, last);
        chk("inv.cnt", cnt, 0);
        drv(0, -5);
        win(6, cnt, last);
        chk("inv.ch0", last, 40);

        // Reset in the middle of an op with a sticky overrun pending.
        drv(3, -1);
        drv(3, -1);
        chk("rst2.ovr_pre", overrun_out, 8'h08);
        rst_n_in = 1'b0;
        #1;
        chk("rst2.dv", dv_out, 0);
        chk("rst2.data", data_out, 0);
        chk("rst2.chan", chan_out, 0);
        chk("rst2.ovr", overrun_out, 0);
        #2 rst_n_in = 1'b1;
        win(6, cnt, last);
        chk("rst2.cnt", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
